uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 Parameter PARITY_EN, default 0, 1 = one even-parity bit between data and stop.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 baud  input  17  selected baud rate in bit/s.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 rx_data  output  8  received byte, LSB = first data bit; bits above DATA_BITS read 0.
REQ-008 rx_valid  output  1  one-cycle pulse; rx_data and error flags are valid.
REQ-009 frame_err  output  1  stop bit of the last completed frame sampled low.
REQ-010 parity_err  output  1  parity mismatch on the last completed frame; always 0 when PARITY_EN=0.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 rx passes through a 2-flop synchronizer; all logic uses the synchronized value rx_s only.
REQ-013 Clocks per bit DIV come from baud: 4800->10416, 9600->5208, 14400->3472, 19200->2604, 38400->1302, 57600->868, any other value->5208.
REQ-014 DIV is latched on start detection; baud changes mid-frame have no effect until the next frame.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE->START on the rx_s high-to-low transition (previous rx_s=1, current rx_s=0); the bit counter clears to 0.
REQ-017 START: sample rx_s at count = DIV/2-1; if 1, glitch -> IDLE with no output; if 0 -> DATA, counter cleared.
REQ-018 DATA: sample at count = DIV-1 (mid-bit), shift in LSB first, clear counter; after DATA_BITS samples -> PARITY if PARITY_EN else STOP.
REQ-019 PARITY: sample at count = DIV-1; parity_err_next = XOR(data bits, parity bit) != 0 -> STOP.
REQ-020 STOP: sample at count = DIV-1; on that same edge rx_data, frame_err (= ~sample), parity_err and rx_valid=1 are registered -> IDLE.
REQ-021 rx_valid is high for exactly one cycle per completed frame, including frames with frame_err or parity_err set.
REQ-022 rx_data, frame_err and parity_err hold their values until the next rx_valid.
REQ-023 After a frame_err (line held low/break), a new start is accepted only after rx_s has returned high (REQ-016 edge rule).
REQ-024 Counter is 14 bits wide and never exceeds DIV-1; it clears on every state transition.
REQ-025 A start edge arriving in the cycle IDLE is re-entered from STOP is detected normally (back-to-back frames with no idle gap).

Reset
REQ-026 On rst: state=IDLE, counter=0, shift register=0, synchronizer flops=1, previous-sample register=1, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, busy=0.
REQ-027 rst asserted mid-frame aborts the frame with no rx_valid; reception resumes with the first start edge after rst deasserts.

Structure
REQ-028 Package uart_pkg holds the FSM state enum, the baud-to-DIV function and its constants (shared with the transmit-side clock generator table).
REQ-029 A single sub-module, uart_rx_sync, implements the 2-flop synchronizer with a reset value of 1.

Verification
REQ-030 baud=9600, frame 0xA5 (8N1) -> rx_valid once, rx_data=0xA5, frame_err=0, rx_valid about 9.5*5208 cycles after the start edge (+/-3 cycles).
REQ-031 baud=57600, three back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three rx_valid pulses in order, with no errors.
REQ-032 baud=9600, rx low for 1000 cycles then high -> no rx_valid; busy returns to 0; the next 0x5A frame is received correctly.
REQ-033 baud=19200, 0x81 with stop bit driven low -> rx_valid with frame_err=1, rx_data=0x81; no new frame until rx returns high.
REQ-034 PARITY_EN=1, baud=4800, 0x07 with parity bit 0 -> parity_err=1; the same frame with parity bit 1 -> parity_err=0.
REQ-035 baud=1234 (unsupported) -> DIV=5208 and 0xC3 is received correctly; rst pulsed during bit 3 of a frame -> no rx_valid and all outputs return to their reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and baud-to-divider table
// Clock is 50 MHz; DIV values are clocks per bit, also used by the transmit-side clock generator.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [13:0] DIV_4800  = 14'd10416;
  localparam logic [13:0] DIV_9600  = 14'd5208;
  localparam logic [13:0] DIV_14400 = 14'd3472;
  localparam logic [13:0] DIV_19200 = 14'd2604;
  localparam logic [13:0] DIV_38400 = 14'd1302;
  localparam logic [13:0] DIV_57600 = 14'd868;
  function automatic logic [13:0] baud_to_div(input logic [16:0] baud);
    return baud == 17'd4800  ? DIV_4800  :
           baud == 17'd14400 ? DIV_14400 :
           baud == 17'd19200 ? DIV_19200 :
           baud == 17'd38400 ? DIV_38400 :
           baud == 17'd57600 ? DIV_57600 : DIV_9600;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the asynchronous rx line, resets to idle-high
// Ports: clk, rst (sync, active-high), d_i async input, q_o synchronized output.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk) ff_q <= rst ? 2'b11 : {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver, DATA_BITS data, optional even parity, one stop bit
// Ports: clk, rst (sync, active-high), baud (bit/s, latched at start), rx (async, idle high),
//        rx_data / frame_err / parity_err (held until next rx_valid), rx_valid (1-cycle pulse), busy.
module uart_rx import uart_pkg::*; #(
  parameter int DATA_BITS = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] baud,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        parity_err,
  output logic        busy
);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
  state_t state_q, state_d;
  logic [13:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic prev_q, par_q, par_d, ferr_q, ferr_d, perr_q, perr_d, valid_q, valid_d;
  logic rx_s, hit;
  uart_rx_sync u_sync (.clk(clk), .rst(rst), .d_i(rx), .q_o(rx_s));
  // START samples half a bit in to find the centre; later bits sample one full bit apart.
  assign hit = cnt_q == (state_q == START ? (div_q >> 1) - 14'd1 : div_q - 14'd1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 14'd1;
    div_d = div_q;
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    data_d = data_q;
    ferr_d = ferr_q;
    perr_d = perr_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) begin
          state_d = START;
          div_d = baud_to_div(baud);
          bit_d = '0;
          sh_d = '0;
        end
      end
      START: if (hit) begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (hit) begin
        cnt_d = '0;
        sh_d[bit_q] = rx_s;
        bit_d = bit_q + 3'd1;
        if (bit_q == LAST) state_d = PARITY_EN ? PARITY : STOP;
      end
      PARITY: if (hit) begin
        cnt_d = '0;
        par_d = ^sh_q ^ rx_s;
        state_d = STOP;
      end
      STOP: if (hit) begin
        cnt_d = '0;
        state_d = IDLE;
        data_d = sh_q;
        ferr_d = ~rx_s;
        perr_d = PARITY_EN & par_q;
        valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= DIV_9600;
      bit_q <= '0;
      sh_q <= '0;
      prev_q <= 1'b1;
      par_q <= 1'b0;
      data_q <= '0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      prev_q <= rx_s;
      par_q <= par_d;
      data_q <= data_d;
      ferr_q <= ferr_d;
      perr_q <= perr_d;
      valid_q <= valid_d;
    end
  end
  assign rx_data = data_q;
  assign rx_valid = valid_q;
  assign frame_err = ferr_q;
  assign parity_err = perr_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (8N1 instance and a 5-bit even-parity instance)
module tb_uart_rx;
  typedef struct packed {
    logic [7:0] d;
    logic fe;
    logic pe;
    logic lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, rst_p = 1'b1;
  logic [16:0] baud = 17'd9600, baud_p = 17'd4800;
  logic rx = 1'b1, rx_p = 1'b1;
  logic [7:0] rx_data, rx_data_p;
  logic rx_valid, frame_err, parity_err, busy;
  logic rx_valid_p, frame_err_p, parity_err_p, busy_p;
  int checks = 0, failures = 0, cyc = 0, t0_m = 0, t0_p = 0, lat = 0;
  bit p_done = 1'b0;
  exp_t q_m[$], q_p[$];
  exp_t em, ep;

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .baud(baud), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy));
  uart_rx #(.DATA_BITS(5), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst(rst_p), .baud(baud_p), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .busy(busy_p));

  initial forever #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", n, act, exp);
    end
  endtask

  task automatic line(input bit p, input logic v, input int cycles);
    if (p) rx_p = v; else rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Expected values are passed in by the caller; t0 is the first clock edge that sees the start bit.
  task automatic send(input bit p, input int div, input logic [7:0] d, input int n, input bit has_par,
                      input logic par_bit, input logic stop, input logic exp_pe, input logic lat_chk);
    if (p) begin q_p.push_back({d, ~stop, exp_pe, lat_chk}); t0_p = cyc + 1; end
    else begin q_m.push_back({d, ~stop, exp_pe, lat_chk}); t0_m = cyc + 1; end
    line(p, 1'b0, div);
    for (int i = 0; i < n; i++) line(p, d[i], div);
    if (has_par) line(p, par_bit, div);
    line(p, stop, div);
    chk(p ? "p_pending" : "m_pending", p ? 32'(q_p.size()) : 32'(q_m.size()), 32'd0);
  endtask

  initial forever begin
    @(negedge clk);
    if (rx_valid === 1'b1) begin
      if (q_m.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL m_spurious_valid: got rx_valid=1 data=%0h, want no rx_valid", rx_data);
      end else begin
        em = q_m.pop_front();
        chk("m_rx_data", 32'(rx_data), 32'(em.d));
        chk("m_frame_err", 32'(frame_err), 32'(em.fe));
        chk("m_parity_err", 32'(parity_err), 32'(em.pe));
        if (em.lat) begin
          lat = cyc - t0_m;
          checks++;
          if (lat < 49473 || lat > 49479) begin
            failures++;
            $display("FAIL m_latency: got %0d cycles, want 49473..49479", lat);
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rx_valid_p === 1'b1) begin
      if (q_p.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL p_spurious_valid: got rx_valid=1 data=%0h, want no rx_valid", rx_data_p);
      end else begin
        ep = q_p.pop_front();
        chk("p_rx_data", 32'(rx_data_p), 32'(ep.d));
        chk("p_frame_err", 32'(frame_err_p), 32'(ep.fe));
        chk("p_parity_err", 32'(parity_err_p), 32'(ep.pe));
      end
    end
  end

  initial begin
    #(20 * 400000);
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("p_rst_parity_err", 32'(parity_err_p), 32'd0);
    chk("p_rst_busy", 32'(busy_p), 32'd0);
    rst_p = 1'b0;
    line(1, 1'b1, 20);
    send(1, 10416, 8'h07, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send(1, 10416, 8'h07, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    p_done = 1'b1;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    line(0, 1'b1, 20);
    send(0, 5208, 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    line(0, 1'b1, 100);
    baud = 17'd57600;
    send(0, 868, 8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(0, 868, 8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(0, 868, 8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    line(0, 1'b1, 100);
    baud = 17'd9600;
    line(0, 1'b0, 500);
    chk("glitch_busy", 32'(busy), 32'd1);
    line(0, 1'b0, 500);
    line(0, 1'b1, 3000);
    chk("glitch_idle", 32'(busy), 32'd0);
    baud = 17'd57600;
    fork
      send(0, 868, 8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      begin repeat (3000) @(negedge clk); baud = 17'd9600; end
    join
    line(0, 1'b1, 100);
    baud = 17'd19200;
    send(0, 2604, 8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    line(0, 1'b0, 3 * 2604);
    chk("break_idle", 32'(busy), 32'd0);
    line(0, 1'b1, 2604);
    baud = 17'd57600;
    send(0, 868, 8'h69, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    line(0, 1'b1, 100);
    baud = 17'd1234;
    send(0, 5208, 8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    line(0, 1'b1, 100);
    baud = 17'd57600;
    line(0, 1'b0, 868);
    for (int i = 0; i < 3; i++) line(0, 1'b0, 868);
    line(0, 1'b1, 434);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    chk("abort_frame_err", 32'(frame_err), 32'd0);
    chk("abort_parity_err", 32'(parity_err), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    line(0, 1'b1, 2000);
    chk("abort_idle", 32'(busy), 32'd0);
    send(0, 868, 8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200000 && !p_done; i++) @(negedge clk);
    chk("p_done", 32'(p_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
